// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: PC width, 2-bit counter encodings,
// control-flow opcodes and a saturating increment helper.
package riscv_pkg;

    localparam int PC_W = 12;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, used as a next-state function per BTB entry.
module sat_counter2
    import riscv_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       en_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (en_i) begin
            if (up_i && ctr_i != CTR_ST)
                ctr_o = ctr_i + 2'd1;
            else if (!up_i && ctr_i != CTR_SNT)
                ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup, registered update.
// Optional macro BP_STATS_EN adds lookup/hit/mispredict statistics counters.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = riscv_pkg::PC_W
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_mispredicts
`endif
);
    import riscv_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [ENTRIES-1:0]                 valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0]      tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]       target_q, target_d;
    logic [ENTRIES-1:0][1:0]            ctr_q, ctr_d, ctr_nxt;
    logic [ENTRIES-1:0]                 cnt_en, alloc;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             hit, u_hit;
    logic             unused_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[PC_W-1:IDX_W+2];
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Lookup reads pre-edge state only; a same-cycle update is not bypassed.
    assign hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_taken  = hit && ctr_q[l_idx][1];
    assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + PC_W'(4);

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        assign cnt_en[g] = upd_valid && u_hit && (u_idx == IDX_W'(g));
        assign alloc[g]  = upd_valid && !u_hit && upd_taken && (u_idx == IDX_W'(g));
        sat_counter2 u_ctr (
            .ctr_i (ctr_q[g]),
            .en_i  (cnt_en[g]),
            .up_i  (upd_taken),
            .ctr_o (ctr_nxt[g])
        );
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_nxt;
        for (int i = 0; i < ENTRIES; i++) begin
            if (alloc[i]) begin
                valid_d[i]  = 1'b1;
                tag_d[i]    = u_tag;
                target_d[i] = upd_target;
                ctr_d[i]    = CTR_WT;
            end else if (cnt_en[i] && upd_taken) begin
                target_d[i] = upd_target;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{CTR_WNT}};
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] lookups_q, lookups_d, hits_q, hits_d, mispred_q, mispred_d;

    always_comb begin
        lookups_d = sat_inc32(lookups_q);
        hits_d    = hit ? sat_inc32(hits_q) : hits_q;
        mispred_d = (upd_valid && upd_mispredict) ? sat_inc32(mispred_q) : mispred_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookups_q <= '0;
            hits_q    <= '0;
            mispred_q <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
            mispred_q <= mispred_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_hits        = hits_q;
    assign stat_mispredicts = mispred_q;
`else
    logic unused_mispredict;
    assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, PC_W=12); define
// BP_STATS_EN to also exercise the statistics counters.
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] lookup_pc, upd_pc, upd_target, pred_target;
    logic        pred_taken, upd_valid, upd_taken, upd_mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

    branch_predictor #(.ENTRIES(16), .PC_W(12)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        taken;
        logic [11:0] target;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled mid-cycle, well clear of the rising edge.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
            check({e.tag, ".target"}, {20'd0, pred_target}, {20'd0, e.target});
        end
    end

    task automatic cyc(input string tag, input logic [11:0] lpc,
                       input logic uv, input logic [11:0] upc, input logic ut,
                       input logic [11:0] utgt, input logic et, input logic [11:0] etgt);
        exp_t e;
        @(posedge CLK);
        #1;
        lookup_pc  = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        e.tag = tag; e.taken = et; e.target = etgt;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1;
        lookup_pc = 12'h010; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_mispredict = 0;
        #12;
        check("rst.taken", {31'd0, pred_taken}, 32'd0);
        check("rst.target", {20'd0, pred_target}, 32'h014);
        @(negedge CLK);
        RST = 1'b0;

        cyc("miss0",   12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h014);
        cyc("wrap",    12'hFFC, 0, 12'h000, 0, 12'h000, 0, 12'h000);
        cyc("alloc",   12'h010, 1, 12'h010, 1, 12'h100, 0, 12'h014);
        cyc("hit",     12'h010, 0, 12'h000, 0, 12'h000, 1, 12'h100);
        cyc("alias",   12'h050, 0, 12'h000, 0, 12'h000, 0, 12'h054);
        // Counter walks 10->11(sat)->10->01->00(sat)->01->10.
        cyc("t1",      12'h010, 1, 12'h010, 1, 12'h100, 1, 12'h100);
        cyc("t2",      12'h010, 1, 12'h010, 1, 12'h100, 1, 12'h100);
        cyc("t3",      12'h010, 1, 12'h010, 1, 12'h100, 1, 12'h100);
        cyc("nt1",     12'h010, 1, 12'h010, 0, 12'h0F0, 1, 12'h100);
        cyc("nt2",     12'h010, 1, 12'h010, 0, 12'h0F0, 1, 12'h100);
        cyc("nt3",     12'h010, 1, 12'h010, 0, 12'h0F0, 0, 12'h014);
        cyc("nt4",     12'h010, 1, 12'h010, 0, 12'h0F0, 0, 12'h014);
        cyc("up1",     12'h010, 1, 12'h010, 1, 12'h100, 0, 12'h014);
        cyc("up2",     12'h010, 1, 12'h010, 1, 12'h200, 0, 12'h014);
        cyc("retgt",   12'h010, 0, 12'h030, 1, 12'h300, 1, 12'h200);
        cyc("hold",    12'h010, 0, 12'h000, 0, 12'h000, 1, 12'h200);
        cyc("noupd",   12'h030, 0, 12'h000, 0, 12'h000, 0, 12'h034);
        cyc("ntmiss",  12'h034, 1, 12'h034, 0, 12'h700, 0, 12'h038);
        cyc("ntmiss2", 12'h034, 0, 12'h000, 0, 12'h000, 0, 12'h038);
        cyc("hazard",  12'h020, 1, 12'h020, 1, 12'h080, 0, 12'h024);
        cyc("hazard2", 12'h020, 0, 12'h000, 0, 12'h000, 1, 12'h080);
        cyc("evict",   12'h050, 1, 12'h050, 1, 12'h400, 0, 12'h054);
        cyc("evict2",  12'h050, 0, 12'h000, 0, 12'h000, 1, 12'h400);
        cyc("evicted", 12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h014);

        // Asynchronous reset mid-cycle with an allocation in flight.
        @(posedge CLK);
        #1;
        lookup_pc = 12'h020; upd_valid = 1; upd_pc = 12'h0A0; upd_taken = 1; upd_target = 12'h500;
        #1;
        check("prerst.taken", {31'd0, pred_taken}, 32'd1);
        #1;
        RST = 1'b1;
        #1;
        check("arst.taken", {31'd0, pred_taken}, 32'd0);
        check("arst.target", {20'd0, pred_target}, 32'h024);
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        upd_valid = 0;

        cyc("post020", 12'h020, 0, 12'h000, 0, 12'h000, 0, 12'h024);
        cyc("post050", 12'h050, 0, 12'h000, 0, 12'h000, 0, 12'h054);
        cyc("post0A0", 12'h0A0, 0, 12'h000, 0, 12'h000, 0, 12'h0A4);
        cyc("post010", 12'h010, 0, 12'h000, 0, 12'h000, 0, 12'h014);
        @(posedge CLK);
        @(negedge CLK);
        check("sb.drain", q.size(), 32'd0);

`ifdef BP_STATS_EN
        RST = 1'b1;
        #2;
        check("stat.rst", stat_lookups | stat_hits | stat_mispredicts, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        lookup_pc = 12'h100; upd_valid = 1; upd_pc = 12'h200; upd_taken = 1;
        upd_target = 12'h300; upd_mispredict = 1;
        for (int c = 2; c <= 10; c++) begin
            @(posedge CLK);
            #1;
            lookup_pc      = (c <= 4) ? 12'h200 : 12'h100;
            upd_valid      = (c == 2);
            upd_pc         = 12'h300;
            upd_taken      = 1'b0;
            upd_mispredict = 1'b1;
        end
        @(posedge CLK);
        #1;
        upd_valid = 0; upd_mispredict = 0;
        check("stat.lookups", stat_lookups, 32'd10);
        check("stat.hits", stat_hits, 32'd3);
        check("stat.mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
